// File: rtl/enemy_hit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_hit_ctrl
//  Purpose  : Bullet-vs-target hit detection, one-target damage per hit,
//             post-hit blanking and HP/alive bookkeeping for boss + 4 enemies.
//  Option   : define BOSS_GATE_EN to make the boss invulnerable while any
//             enemy is still alive.
//  Revision : 1.0  initial release
// ============================================================================
module enemy_hit_ctrl #(
    parameter logic [6:0] ENM_HP_INIT  = 7'd40,
    parameter logic [9:0] BOSS_HP_INIT = 10'd600,
    parameter logic [6:0] ENM_DMG      = 7'd2,
    parameter logic [9:0] BOSS_DMG     = 10'd2,
    parameter int         ENM_HW       = 15,
    parameter int         ENM_HH       = 18,
    parameter int         BOSS_HW      = 41,
    parameter int         BOSS_HH      = 24,
    parameter int         COOLDOWN     = 4
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic [9:0] reimu_bulletx,
    input  logic [9:0] reimu_bullety,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic [9:0] enmx1,
    input  logic [9:0] enmx2,
    input  logic [9:0] enmx3,
    input  logic [9:0] enmx4,
    input  logic [9:0] enmy1,
    input  logic [9:0] enmy2,
    input  logic [9:0] enmy3,
    input  logic [9:0] enmy4,
    output logic       bullet_hit,
    output logic [6:0] enmhp1,
    output logic [6:0] enmhp2,
    output logic [6:0] enmhp3,
    output logic [6:0] enmhp4,
    output logic [9:0] bosshp,
    output logic [3:0] enm_alive,
    output logic       boss_alive,
    output logic       all_clear
);

    localparam logic [10:0] c_ENM_HW  = 11'(ENM_HW);
    localparam logic [10:0] c_ENM_HH  = 11'(ENM_HH);
    localparam logic [10:0] c_BOSS_HW = 11'(BOSS_HW);
    localparam logic [10:0] c_BOSS_HH = 11'(BOSS_HH);

    localparam int                 c_CNT_W    = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(COOLDOWN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_ARMED = 1'b0;
    localparam logic [0:0] c_ST_BLANK = 1'b1;

    localparam logic [2:0] c_SEL_BOSS = 3'd0;

    logic [6:0]         r_enm_hp [4];
    logic [9:0]         r_boss_hp;
    logic               r_hit_vld;
    logic [2:0]         r_hit_sel;
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bullet_hit;
    logic               r_all_clear;

    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [9:0]  w_enmx [4];
    logic [9:0]  w_enmy [4];
    logic [3:0]  w_enm_hit;
    logic        w_boss_hit;
    logic        w_vld;
    logic [2:0]  w_sel;
    logic        w_all_zero;

    assign w_bx = {1'b0, reimu_bulletx};
    assign w_by = {1'b0, reimu_bullety};

    assign w_enmx[0] = enmx1;
    assign w_enmx[1] = enmx2;
    assign w_enmx[2] = enmx3;
    assign w_enmx[3] = enmx4;
    assign w_enmy[0] = enmy1;
    assign w_enmy[1] = enmy2;
    assign w_enmy[2] = enmy3;
    assign w_enmy[3] = enmy4;

    // Strict lower bound: a centre closer to 0 than the half-size leaves
    // the lower edge below zero, so every position passes that side.
    for (genvar gi = 0; gi < 4; gi++) begin : g_enm
        logic [10:0] w_cx;
        logic [10:0] w_cy;
        logic        w_x_ok;
        logic        w_y_ok;

        assign w_cx   = {1'b0, w_enmx[gi]};
        assign w_cy   = {1'b0, w_enmy[gi]};
        assign w_x_ok = ((w_cx < c_ENM_HW) || (w_bx > (w_cx - c_ENM_HW)))
                        && (w_bx < (w_cx + c_ENM_HW));
        assign w_y_ok = ((w_cy < c_ENM_HH) || (w_by > (w_cy - c_ENM_HH)))
                        && (w_by < (w_cy + c_ENM_HH));

        assign enm_alive[gi] = (r_enm_hp[gi] != 7'd0);
        assign w_enm_hit[gi] = w_x_ok && w_y_ok && enm_alive[gi];
    end

    logic [10:0] w_boss_cx;
    logic [10:0] w_boss_lo;
    logic        w_boss_raw;

    assign w_boss_cx  = {1'b0, bossx};
    assign w_boss_lo  = (w_boss_cx >= c_BOSS_HW) ? (w_boss_cx - c_BOSS_HW) : 11'd0;
    assign boss_alive = (r_boss_hp != 10'd0);
    assign w_boss_raw = (w_bx >= w_boss_lo) && (w_bx <= (w_boss_cx + c_BOSS_HW))
                        && (w_by <= ({1'b0, bossy} + c_BOSS_HH)) && boss_alive;

`ifdef BOSS_GATE_EN
    assign w_boss_hit = w_boss_raw && (enm_alive == 4'b0000);
`else
    assign w_boss_hit = w_boss_raw;
`endif

    always_comb begin
        w_vld = w_boss_hit || (|w_enm_hit);
        w_sel = c_SEL_BOSS;
        if (w_boss_hit)        w_sel = c_SEL_BOSS;
        else if (w_enm_hit[0]) w_sel = 3'd1;
        else if (w_enm_hit[1]) w_sel = 3'd2;
        else if (w_enm_hit[2]) w_sel = 3'd3;
        else if (w_enm_hit[3]) w_sel = 3'd4;
    end

    assign w_all_zero = (enm_alive == 4'b0000) && !boss_alive;

    function automatic logic [6:0] f_enm_sub(input logic [6:0] hp);
        return (hp <= ENM_DMG) ? 7'd0 : (hp - ENM_DMG);
    endfunction

    function automatic logic [9:0] f_boss_sub(input logic [9:0] hp);
        return (hp <= BOSS_DMG) ? 10'd0 : (hp - BOSS_DMG);
    endfunction

    always_ff @(posedge clk_22) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_enm_hp[i] <= ENM_HP_INIT;
            r_boss_hp    <= BOSS_HP_INIT;
            r_hit_vld    <= 1'b0;
            r_hit_sel    <= c_SEL_BOSS;
            r_state      <= c_ST_ARMED;
            r_cnt        <= '0;
            r_bullet_hit <= 1'b0;
            r_all_clear  <= 1'b0;
        end else begin
            r_hit_vld    <= w_vld;
            r_hit_sel    <= w_sel;
            r_bullet_hit <= 1'b0;
            r_all_clear  <= r_all_clear | w_all_zero;
            case (r_state)
                c_ST_ARMED: begin
                    if (r_hit_vld) begin
                        if (r_hit_sel == c_SEL_BOSS) r_boss_hp <= f_boss_sub(r_boss_hp);
                        for (int i = 0; i < 4; i++) begin
                            if (r_hit_sel == 3'(i + 1)) r_enm_hp[i] <= f_enm_sub(r_enm_hp[i]);
                        end
                        r_bullet_hit <= 1'b1;
                        r_cnt        <= c_CNT_LOAD;
                        r_state      <= c_ST_BLANK;
                    end
                end
                c_ST_BLANK: begin
                    // Flags sampled here belong to the bullet that just hit.
                    if (r_cnt == '0) r_state <= c_ST_ARMED;
                    else             r_cnt   <= r_cnt - c_CNT_ONE;
                end
                default: r_state <= c_ST_ARMED;
            endcase
        end
    end

    assign bullet_hit = r_bullet_hit;
    assign enmhp1     = r_enm_hp[0];
    assign enmhp2     = r_enm_hp[1];
    assign enmhp3     = r_enm_hp[2];
    assign enmhp4     = r_enm_hp[3];
    assign bosshp     = r_boss_hp;
    assign all_clear  = r_all_clear;

endmodule
`default_nettype wire

// File: tb/tb_enemy_hit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enemy_hit_ctrl
//  Purpose  : Directed + randomized bench for enemy_hit_ctrl against a
//             cycle-abstract reference model of hit, damage and blanking.
//  Revision : 1.0  initial release
// ============================================================================
module tb_enemy_hit_ctrl;

    localparam int c_ENM_HP  = 40;
    localparam int c_BOSS_HP = 600;
    localparam int c_EDMG    = 2;
    localparam int c_BDMG    = 2;
    localparam int c_COOL    = 4;

    logic       clk_22 = 1'b0;
    logic       rst    = 1'b1;
    logic [9:0] bx, by, bossx, bossy;
    logic [9:0] ex [4];
    logic [9:0] ey [4];
    logic       bullet_hit;
    logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
    logic [9:0] bosshp;
    logic [3:0] enm_alive;
    logic       boss_alive;
    logic       all_clear;

    always #5 clk_22 = ~clk_22;

    enemy_hit_ctrl dut (
        .clk_22        (clk_22),
        .rst           (rst),
        .reimu_bulletx (bx),
        .reimu_bullety (by),
        .bossx         (bossx),
        .bossy         (bossy),
        .enmx1         (ex[0]),
        .enmx2         (ex[1]),
        .enmx3         (ex[2]),
        .enmx4         (ex[3]),
        .enmy1         (ey[0]),
        .enmy2         (ey[1]),
        .enmy3         (ey[2]),
        .enmy4         (ey[3]),
        .bullet_hit    (bullet_hit),
        .enmhp1        (enmhp1),
        .enmhp2        (enmhp2),
        .enmhp3        (enmhp3),
        .enmhp4        (enmhp4),
        .bosshp        (bosshp),
        .enm_alive     (enm_alive),
        .boss_alive    (boss_alive),
        .all_clear     (all_clear)
    );

    // Reference model: HP values, the target struck one edge ago, and the
    // earliest edge at which damage may land again.
    int m_ehp [4];
    int m_bhp;
    int m_pend;
    int m_edge;
    int m_next_ok;
    int m_pulse;
    int m_ac;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int pick_target();
        int x, y;
        bit boss;
        x = int'(bx);
        y = int'(by);
        boss = (m_bhp > 0) && (x >= int'(bossx) - 41) && (x <= int'(bossx) + 41)
               && (y <= int'(bossy) + 24);
`ifdef BOSS_GATE_EN
        boss = boss && (m_ehp[0] == 0) && (m_ehp[1] == 0) && (m_ehp[2] == 0) && (m_ehp[3] == 0);
`endif
        if (boss) return 0;
        for (int i = 0; i < 4; i++) begin
            if (m_ehp[i] > 0 && (int'(ex[i]) - 15 < x) && (x < int'(ex[i]) + 15)
                && (int'(ey[i]) - 18 < y) && (y < int'(ey[i]) + 18)) return i + 1;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int nxt;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_ehp[i] = c_ENM_HP;
            m_bhp = c_BOSS_HP; m_pend = -1; m_next_ok = 0; m_pulse = 0; m_ac = 0;
        end else begin
            nxt = pick_target();
            if (m_ehp[0] == 0 && m_ehp[1] == 0 && m_ehp[2] == 0 && m_ehp[3] == 0 && m_bhp == 0)
                m_ac = 1;
            m_pulse = 0;
            if (m_pend >= 0 && m_edge >= m_next_ok) begin
                if (m_pend == 0) m_bhp = (m_bhp <= c_BDMG) ? 0 : m_bhp - c_BDMG;
                else m_ehp[m_pend-1] = (m_ehp[m_pend-1] <= c_EDMG) ? 0 : m_ehp[m_pend-1] - c_EDMG;
                m_pulse   = 1;
                m_next_ok = m_edge + c_COOL + 1;
            end
            m_pend = nxt;
        end
        m_edge++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m_edge);
        end
    endtask

    task automatic check_all();
        logic [3:0] alive;
        for (int i = 0; i < 4; i++) alive[i] = (m_ehp[i] != 0);
        check("bullet_hit", 32'(bullet_hit), 32'(m_pulse));
        check("enmhp1", 32'(enmhp1), 32'(m_ehp[0]));
        check("enmhp2", 32'(enmhp2), 32'(m_ehp[1]));
        check("enmhp3", 32'(enmhp3), 32'(m_ehp[2]));
        check("enmhp4", 32'(enmhp4), 32'(m_ehp[3]));
        check("bosshp", 32'(bosshp), 32'(m_bhp));
        check("enm_alive", 32'(enm_alive), 32'(alive));
        check("boss_alive", 32'(boss_alive), 32'(m_bhp != 0));
        check("all_clear", 32'(all_clear), 32'(m_ac));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_22);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic aim(input int x, input int y);
        bx = 10'((x < 0) ? 0 : (x > 1023) ? 1023 : x);
        by = 10'((y < 0) ? 0 : (y > 1023) ? 1023 : y);
    endtask

    task automatic aim_at(input int t, input int jit);
        int ox, oy;
        ox = (jit > 0) ? int'($urandom_range(0, 2 * jit)) - jit : 0;
        oy = (jit > 0) ? int'($urandom_range(0, 2 * jit)) - jit : 0;
        if (t == 0) aim(int'(bossx) + ox, int'(bossy) + oy);
        else        aim(int'(ex[t-1]) + ox, int'(ey[t-1]) + oy);
    endtask

    initial begin
        int guard;
        m_edge = 0;
        bossx = 10'd500; bossy = 10'd100;
        ex[0] = 10'd100; ey[0] = 10'd200;
        ex[1] = 10'd200; ey[1] = 10'd300;
        ex[2] = 10'd300; ey[2] = 10'd300;
        ex[3] = 10'd5;   ey[3] = 10'd400;
        aim(900, 900);

        rst = 1'b1;
        tick(3);
        check("reset_alive", 32'(enm_alive), 32'hF);
        rst = 1'b0;

        // Single enemy hit, then position held through blanking.
        aim(100, 200);
        tick(2);
        check("e1_pulse", 32'(bullet_hit), 32'd1);
        check("e1_hp", 32'(enmhp1), 32'd38);
        tick(4);
        check("e1_blank_hp", 32'(enmhp1), 32'd38);
        tick(2);
        aim(900, 900);
        tick(6);

        // Strict right edge, then one pixel inside.
        aim(115, 200);
        tick(8);
        aim(114, 200);
        tick(3);
        aim(900, 900);
        tick(6);

        // Lower bound clamp: enemy at x=5, bullet at x=0.
        aim(0, 400);
        tick(3);
        aim(900, 900);
        tick(6);

        // Boss and enemy2 overlapping.
        ex[1] = 10'd500; ey[1] = 10'd110;
        aim(500, 110);
        tick(3);
        aim(900, 900);
        ex[1] = 10'd200; ey[1] = 10'd300;
        tick(6);

        // Reset one cycle after a pulse, then immediate overlap.
        aim(100, 200);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        aim(900, 900);
        tick(6);

        // Randomized aiming with rare resets.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) < 6) aim_at(int'($urandom_range(0, 4)), 22);
            else aim(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        aim(900, 900);
        tick(6);

        // Kill every enemy, then the boss.
        for (int t = 1; t <= 5; t++) begin
            guard = 0;
            aim_at(t % 5, 0);
            while (((t < 5) ? m_ehp[t-1] : m_bhp) > 0 && guard < 3000) begin
                tick(1);
                guard++;
            end
            check("kill_hp", (t == 1) ? 32'(enmhp1) : (t == 2) ? 32'(enmhp2) :
                  (t == 3) ? 32'(enmhp3) : (t == 4) ? 32'(enmhp4) : 32'(bosshp), 32'd0);
        end
        tick(3);
        check("all_clear", 32'(all_clear), 32'd1);
        check("dead_alive", 32'(enm_alive), 32'd0);

        // Dead targets are transparent.
        aim(100, 200);
        tick(6);
        aim(500, 100);
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
